// File: rtl/nios2_irq_ctrl_pkg.sv
// Shared constants for the Nios II interrupt aggregator: register word
// addresses, the source-count ceiling and the ACTIVE_ID layout, plus the
// lowest-set-bit helper used by the priority encoder.
package nios2_irq_pkg;

  localparam logic [2:0] ADDR_PENDING   = 3'd0;
  localparam logic [2:0] ADDR_MASK      = 3'd1;
  localparam logic [2:0] ADDR_MODE      = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE_ID = 3'd3;
  localparam logic [2:0] ADDR_OVERRUN   = 3'd4;

  localparam int IRQ_MAX_SRC      = 16;
  localparam int ACTIVE_VALID_BIT = 15;

  // Index of the lowest set bit; 0 when nothing is set (caller checks valid).
  function automatic logic [3:0] lowest_set_idx(input logic [IRQ_MAX_SRC-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/nios2_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator register file.
interface nios2_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_irq_ctrl_src_cell.sv
// One interrupt source: delayed input (src_d), edge detect, PENDING bit and,
// when IRQ_CTRL_OVERRUN_EN is defined, the OVERRUN bit.
module nios2_irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,      // 1 = edge, 0 = level
  input  logic w1c_pend,
  input  logic w1c_ovr,
  output logic pending,
  output logic overrun
);

  logic src_dly_q;
  logic pend_q, pend_d;
  logic rise;

  // Edge mode: a rise always beats a same-cycle clear so no event is lost.
  // Level mode: the bit simply tracks the source.
  always_comb begin
    rise   = src & ~src_dly_q;
    pend_d = mode ? (rise | (pend_q & ~w1c_pend)) : src;
  end

  // Delayed source and pending bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_dly_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      src_dly_q <= src;
      pend_q    <= pend_d;
    end
  end

  assign pending = pend_q;

`ifdef IRQ_CTRL_OVERRUN_EN
  logic ovr_q, ovr_d;

  // A second rise while still pending (and not being cleared) is an overrun.
  always_comb begin
    ovr_d = (mode & rise & pend_q & ~w1c_pend) | (ovr_q & ~w1c_ovr);
  end

  // Overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign overrun = ovr_q;
`else
  logic unused_w1c_ovr;
  assign unused_w1c_ovr = w1c_ovr;
  assign overrun        = 1'b0;
`endif

endmodule

// File: rtl/nios2_irq_ctrl.sv
// Avalon-MM interrupt aggregator for the Nios II. Holds MASK/MODE, the
// per-source cells, the ACTIVE_ID priority encoder, the read mux and the
// registered irq/readdata outputs.
// Optional feature macro: IRQ_CTRL_OVERRUN_EN (adds OVERRUN flags at address 4).
module nios2_irq_ctrl
  import nios2_irq_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  nios2_irq_ctrl_if.slave  bus,
  output logic             irq
);

  logic             wr;
  logic [N_SRC-1:0] w1c_pend, w1c_ovr;
  logic [N_SRC-1:0] pending, overrun;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_masked;
  logic [15:0]      pend_ext, mask_ext, mode_ext, ovr_ext, masked_ext;
  logic [15:0]      active_id;
  logic [15:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             unused_wdata;

  // Writedata bits above N_SRC are intentionally ignored.
  assign unused_wdata = ^bus.writedata;

  // Write strobes and W1C vectors.
  always_comb begin
    wr       = bus.chipselect & ~bus.write_n;
    w1c_pend = '0;
    w1c_ovr  = '0;
    if (wr && bus.address == ADDR_PENDING) w1c_pend = bus.writedata[N_SRC-1:0];
    if (wr && bus.address == ADDR_OVERRUN) w1c_ovr  = bus.writedata[N_SRC-1:0];
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_cell
    nios2_irq_src_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .src      (irq_src[g]),
      .mode     (mode_q[g]),
      .w1c_pend (w1c_pend[g]),
      .w1c_ovr  (w1c_ovr[g]),
      .pending  (pending[g]),
      .overrun  (overrun[g])
    );
  end

  // MASK / MODE next-state from bus writes.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr && bus.address == ADDR_MASK) mask_d = bus.writedata[N_SRC-1:0];
    if (wr && bus.address == ADDR_MODE) mode_d = bus.writedata[N_SRC-1:0];
  end

  // Zero-extend the per-source vectors and encode ACTIVE_ID.
  always_comb begin
    pend_masked = pending & mask_q;
    pend_ext    = '0;
    mask_ext    = '0;
    mode_ext    = '0;
    ovr_ext     = '0;
    masked_ext  = '0;
    pend_ext[N_SRC-1:0]   = pending;
    mask_ext[N_SRC-1:0]   = mask_q;
    mode_ext[N_SRC-1:0]   = mode_q;
    ovr_ext[N_SRC-1:0]    = overrun;
    masked_ext[N_SRC-1:0] = pend_masked;
    active_id = '0;
    if (|masked_ext) begin
      active_id[ACTIVE_VALID_BIT] = 1'b1;
      active_id[3:0]              = lowest_set_idx(masked_ext);
    end
  end

  // Read mux (sampled every cycle regardless of chipselect) and irq aggregate.
  always_comb begin
    unique case (bus.address)
      ADDR_PENDING:   rdata_d = pend_ext;
      ADDR_MASK:      rdata_d = mask_ext;
      ADDR_MODE:      rdata_d = mode_ext;
      ADDR_ACTIVE_ID: rdata_d = active_id;
      ADDR_OVERRUN:   rdata_d = ovr_ext;
      default:        rdata_d = '0;
    endcase
    irq_d = |pend_masked;
  end

  // Configuration and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      mode_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule
